// File: rtl/ln_pack_pkg.sv
// Shared types and constants for the LayerNorm output byte packer.
package ln_pack_pkg;

  localparam int BYTES  = 8;
  localparam int OUT_W  = 64;
  localparam int CNT_W  = 32;
  localparam int LANE_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Contiguous low-order mask covering lanes 0..lane.
  function automatic logic [BYTES-1:0] keep_of(input logic [LANE_W-1:0] lane);
    logic [BYTES-1:0] k;
    for (int i = 0; i < BYTES; i++) begin
      k[i] = (LANE_W'(i) <= lane);
    end
    return k;
  endfunction

endpackage

// File: rtl/ln_pack_outreg.sv
// Single-entry output register; contents held until m_valid && m_ready, flush drops them.
module ln_pack_outreg #(
  parameter int OUT_W = 64,
  parameter int BYTES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [BYTES-1:0] load_keep,
  input  logic             load_last,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic [BYTES-1:0] m_keep,
  output logic             m_last,
  output logic             free
);

  assign free = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ln_out_packer.sv
// Packs the LayerNorm byte stream into 64-bit words with keep mask and frame tracking.
// Build option LN_PACK_LAST_CHECK_EN: frame ends on the byte count and s_last is only checked.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting and packing bytes
// DRAIN | final word held until m_ready
// DONE  | one cycle, done asserted
module ln_out_packer #(
  parameter int OUT_W = ln_pack_pkg::OUT_W,
  parameter int BYTES = ln_pack_pkg::BYTES,
  parameter int CNT_W = ln_pack_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       Channel_Nums,
  input  logic [19:0]      Token_Nums,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [BYTES-1:0] m_keep,
  output logic             m_last,
  output logic             done,
  output logic             err
);

  import ln_pack_pkg::*;

  state_t              state, state_nxt;
  logic [LANE_W-1:0]   lane;
  logic [OUT_W-1:0]    acc, acc_nxt;
  logic [CNT_W-1:0]    total_in;
  logic                free, accept, final_byte, close;

  assign total_in = CNT_W'(Channel_Nums) * CNT_W'(Token_Nums);

`ifdef LN_PACK_LAST_CHECK_EN
  logic [CNT_W-1:0] total, byte_cnt;

  assign final_byte = (byte_cnt == total - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      total    <= '0;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else if (start) begin
      total    <= total_in;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      if (s_last != final_byte) err <= 1'b1;
    end
  end
`else
  assign final_byte = s_last;
  assign err        = 1'b0;
`endif

  always_comb begin
    s_ready   = (state == RUN) && free;
    accept    = s_valid && s_ready;
    close     = accept && ((lane == LANE_W'(BYTES - 1)) || final_byte);
    done      = (state == DONE);
    acc_nxt   = acc;
    acc_nxt[8*lane +: 8] = s_data;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (accept && final_byte) state_nxt = DRAIN;
      DRAIN:   if (m_valid && m_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // start overrides everything, including an abort mid-frame
    if (start) state_nxt = (total_in == '0) ? DONE : RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane  <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        lane <= '0;
        acc  <= '0;
      end else if (accept) begin
        if (close) begin
          lane <= '0;
          acc  <= '0;
        end else begin
          lane <= lane + LANE_W'(1);
          acc  <= acc_nxt;
        end
      end
    end
  end

  ln_pack_outreg #(.OUT_W(OUT_W), .BYTES(BYTES)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .load      (close),
    .load_data (acc_nxt),
    .load_keep (keep_of(lane)),
    .load_last (final_byte),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .free      (free)
  );

endmodule
